// File: rtl/nv_ram_fifo_ctrl_512x256_pkg.sv
// Shared sizing constants and output-buffer operation decode for the
// 512x256 RAM-backed FIFO controller.
package nv_ram_fifo_ctrl_512x256_pkg;

   localparam int FIFO_DEPTH = 512;
   localparam int FIFO_AW    = 9;
   localparam int FIFO_DW    = 256;
   localparam int CNT_W      = 10;
   localparam int OB_CNT_W   = 2;
   localparam int PWR_W      = 32;

   typedef enum logic [1:0] {
      OB_HOLD,
      OB_LOAD,
      OB_POP,
      OB_SWAP
   } ob_op_e;

   function automatic ob_op_e obuf_op(input logic load, input logic pop);
      case ({load, pop})
         2'b10:   return OB_LOAD;
         2'b01:   return OB_POP;
         2'b11:   return OB_SWAP;
         default: return OB_HOLD;
      endcase
   endfunction

endpackage

// File: rtl/nv_ram_fifo_obuf.sv
// Two-entry ordered register queue that absorbs RAM read data and presents
// it to the consumer as a registered valid/ready stream.
module nv_ram_fifo_obuf
   import nv_ram_fifo_ctrl_512x256_pkg::*;
#(
   parameter int DW = FIFO_DW
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                in_vld,
   input  logic [DW-1:0]       in_pd,
   output logic                out_vld,
   input  logic                out_rdy,
   output logic [DW-1:0]       out_pd,
   output logic [OB_CNT_W-1:0] cnt
);

   logic [DW-1:0]       r_head;
   logic [DW-1:0]       r_tail;
   logic [OB_CNT_W-1:0] r_cnt;

   logic                w_pop;
   ob_op_e              w_op;
   logic [DW-1:0]       w_head_nxt;
   logic [DW-1:0]       w_tail_nxt;
   logic [OB_CNT_W-1:0] w_cnt_nxt;

   always_comb begin
      w_pop      = (r_cnt != '0) & out_rdy;
      w_op       = obuf_op(in_vld, w_pop);
      w_head_nxt = r_head;
      w_tail_nxt = r_tail;
      w_cnt_nxt  = r_cnt;
      case (w_op)
         OB_LOAD: begin
            if (r_cnt == '0) begin
               w_head_nxt = in_pd;
               w_cnt_nxt  = OB_CNT_W'(1);
            end else begin
               w_tail_nxt = in_pd;
               w_cnt_nxt  = OB_CNT_W'(2);
            end
         end
         OB_POP: begin
            w_head_nxt = r_tail;
            w_cnt_nxt  = r_cnt - OB_CNT_W'(1);
         end
         // Head leaves and the new word lands behind whatever remains.
         OB_SWAP: begin
            if (r_cnt == OB_CNT_W'(1)) begin
               w_head_nxt = in_pd;
            end else begin
               w_head_nxt = r_tail;
               w_tail_nxt = in_pd;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_head <= '0;
         r_tail <= '0;
         r_cnt  <= '0;
      end else begin
         r_head <= w_head_nxt;
         r_tail <= w_tail_nxt;
         r_cnt  <= w_cnt_nxt;
      end
   end

   assign out_vld = (r_cnt != '0);
   assign out_pd  = r_head;
   assign cnt     = r_cnt;

endmodule

// File: rtl/nv_ram_fifo_ctrl_512x256.sv
// Ready/valid FIFO controller sequencing a 512x256 two-port RAM as a circular
// buffer, with a 2-entry output buffer hiding the RAM read latency.
module nv_ram_fifo_ctrl_512x256
   import nv_ram_fifo_ctrl_512x256_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH,
   parameter int AW    = FIFO_AW,
   parameter int DW    = FIFO_DW
) (
   input  logic             nvdla_core_clk,
   input  logic             nvdla_core_rstn,
   input  logic             wr_pvld,
   output logic             wr_prdy,
   input  logic [DW-1:0]    wr_pd,
   output logic             rd_pvld,
   input  logic             rd_prdy,
   output logic [DW-1:0]    rd_pd,
   output logic             ram_we,
   output logic [AW-1:0]    ram_wa,
   output logic [DW-1:0]    ram_di,
   output logic             ram_re,
   output logic [AW-1:0]    ram_ra,
   input  logic [DW-1:0]    ram_dout,
   output logic [CNT_W-1:0] fifo_cnt,
   output logic             idle,
   input  logic [PWR_W-1:0] pwrbus_ram_pd,
   output logic [PWR_W-1:0] ram_pwrbus_pd
);

   logic [AW-1:0]       r_wr_ptr;
   logic [AW-1:0]       r_rd_ptr;
   logic [CNT_W-1:0]    r_ram_cnt;
   logic                r_infl;
   logic                r_wr_prdy;
   logic [CNT_W-1:0]    r_fifo_cnt;

   logic                w_push;
   logic                w_pop;
   logic                w_issue;
   logic                w_ob_vld;
   logic [DW-1:0]       w_ob_pd;
   logic [OB_CNT_W-1:0] w_ob_cnt;
   logic [CNT_W-1:0]    w_slots_used;
   logic [CNT_W-1:0]    w_ram_cnt_nxt;

   assign w_push = wr_pvld & r_wr_prdy;
   assign w_pop  = w_ob_vld & rd_prdy;

   // Issue only when the word returning next cycle is guaranteed a slot.
   assign w_slots_used  = CNT_W'(w_ob_cnt) + CNT_W'(r_infl);
   assign w_issue       = (r_ram_cnt != '0) && (w_slots_used < (CNT_W'(2) + CNT_W'(w_pop)));
   assign w_ram_cnt_nxt = r_ram_cnt + CNT_W'(w_push) - CNT_W'(w_issue);

   always_ff @(posedge nvdla_core_clk) begin
      if (!nvdla_core_rstn) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_ram_cnt  <= '0;
         r_infl     <= 1'b0;
         r_wr_prdy  <= 1'b0;
         r_fifo_cnt <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_issue) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_ram_cnt  <= w_ram_cnt_nxt;
         r_infl     <= w_issue;
         r_wr_prdy  <= (w_ram_cnt_nxt < CNT_W'(DEPTH));
         r_fifo_cnt <= r_fifo_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
      end
   end

   nv_ram_fifo_obuf #(
      .DW (DW)
   ) u_obuf (
      .clk     (nvdla_core_clk),
      .rstn    (nvdla_core_rstn),
      .in_vld  (r_infl),
      .in_pd   (ram_dout),
      .out_vld (w_ob_vld),
      .out_rdy (rd_prdy),
      .out_pd  (w_ob_pd),
      .cnt     (w_ob_cnt)
   );

   assign wr_prdy       = r_wr_prdy;
   assign rd_pvld       = w_ob_vld;
   assign rd_pd         = w_ob_pd;
   assign ram_we        = w_push;
   assign ram_wa        = r_wr_ptr;
   assign ram_di        = wr_pd;
   assign ram_re        = w_issue;
   assign ram_ra        = r_rd_ptr;
   assign fifo_cnt      = r_fifo_cnt;
   assign idle          = (r_fifo_cnt == '0);
   assign ram_pwrbus_pd = pwrbus_ram_pd;

endmodule

// File: tb/tb_nv_ram_fifo_ctrl_512x256.sv
// Randomized bench for the RAM FIFO controller against a queue-based model.
module tb_nv_ram_fifo_ctrl_512x256;

   localparam int DEPTH = 512;
   localparam int AW    = 9;
   localparam int DW    = 256;

   logic             clk = 1'b0;
   logic             rstn = 1'b0;
   logic             wr_pvld = 1'b0;
   logic             wr_prdy;
   logic [DW-1:0]    wr_pd = '0;
   logic             rd_pvld;
   logic             rd_prdy = 1'b0;
   logic [DW-1:0]    rd_pd;
   logic             ram_we;
   logic [AW-1:0]    ram_wa;
   logic [DW-1:0]    ram_di;
   logic             ram_re;
   logic [AW-1:0]    ram_ra;
   logic [DW-1:0]    ram_dout = '0;
   logic [9:0]       fifo_cnt;
   logic             idle;
   logic [31:0]      pwrbus_ram_pd = 32'h5A3C_0F81;
   logic [31:0]      ram_pwrbus_pd;

   always #5 clk = ~clk;

   nv_ram_fifo_ctrl_512x256 dut (
      .nvdla_core_clk  (clk),
      .nvdla_core_rstn (rstn),
      .wr_pvld         (wr_pvld),
      .wr_prdy         (wr_prdy),
      .wr_pd           (wr_pd),
      .rd_pvld         (rd_pvld),
      .rd_prdy         (rd_prdy),
      .rd_pd           (rd_pd),
      .ram_we          (ram_we),
      .ram_wa          (ram_wa),
      .ram_di          (ram_di),
      .ram_re          (ram_re),
      .ram_ra          (ram_ra),
      .ram_dout        (ram_dout),
      .fifo_cnt        (fifo_cnt),
      .idle            (idle),
      .pwrbus_ram_pd   (pwrbus_ram_pd),
      .ram_pwrbus_pd   (ram_pwrbus_pd)
   );

   // Behavioural two-port RAM with one-cycle read latency.
   logic [DW-1:0] mem [DEPTH];
   always @(posedge clk) begin
      if (ram_we) mem[ram_wa] <= ram_di;
      if (ram_re) ram_dout <= mem[ram_ra];
   end

   int unsigned n_chk = 0;
   int unsigned n_err = 0;

   task automatic chk_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference model: ordered contents plus totals since the last reset.
   logic [DW-1:0] q[$];
   int  n_push = 0, n_pop = 0, n_iss = 0, since_rst = 0, pops_total = 0;
   bit  model_ok = 1'b0;

   function automatic logic [DW-1:0] rnd_word();
      logic [DW-1:0] w;
      for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
      return w;
   endfunction

   // One clock: check and update model at the falling edge, return just after the rising edge.
   task automatic cyc();
      bit push, pop;
      @(negedge clk);
      push = wr_pvld && wr_prdy;
      pop  = rd_pvld && rd_prdy;
      if (model_ok) begin
         chk_eq("fifo_cnt", DW'(fifo_cnt), DW'(q.size()));
         chk_eq("idle", DW'(idle), DW'(q.size() == 0));
         chk_eq("ram_we", DW'(ram_we), DW'(push));
         if (since_rst == 0) chk_eq("wr_prdy_rst", DW'(wr_prdy), DW'(0));
         else if (q.size() < DEPTH) chk_eq("wr_prdy_open", DW'(wr_prdy), DW'(1));
         else if (q.size() == DEPTH + 2) chk_eq("wr_prdy_full", DW'(wr_prdy), DW'(0));
         if (push) begin
            chk_eq("ram_wa", DW'(ram_wa), DW'(n_push % DEPTH));
            chk_eq("ram_di", ram_di, wr_pd);
         end
         if (ram_re) begin
            chk_eq("re_has_data", DW'((n_push - n_iss) > 0), DW'(1));
            chk_eq("re_free_slot", DW'((n_iss - n_pop) + 1 - int'(pop) <= 2), DW'(1));
            chk_eq("ram_ra", DW'(ram_ra), DW'(n_iss % DEPTH));
         end
         if (rd_pvld) begin
            chk_eq("pvld_nonempty", DW'(q.size() > 0), DW'(1));
            if (q.size() > 0) chk_eq("rd_pd", rd_pd, q[0]);
         end
      end
      if (!rstn) begin
         q.delete();
         n_push = 0; n_pop = 0; n_iss = 0; since_rst = 0;
         model_ok = 1'b1;
      end else if (model_ok) begin
         if (pop && q.size() > 0) begin
            void'(q.pop_front());
            n_pop++;
            pops_total++;
         end
         if (push) begin
            q.push_back(wr_pd);
            n_push++;
         end
         if (ram_re) n_iss++;
         since_rst++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      wr_pvld = 1'b0;
      rd_prdy = 1'b1;
      for (int i = 0; i < 700 && q.size() > 0; i++) cyc();
      chk_eq("drain_empty", DW'(q.size()), DW'(0));
      rd_prdy = 1'b0;
   endtask

   initial begin
      int waited, p0, cycles;

      // Reset values
      repeat (3) cyc();
      #1;
      chk_eq("rst_wr_prdy", DW'(wr_prdy), DW'(0));
      chk_eq("rst_rd_pvld", DW'(rd_pvld), DW'(0));
      chk_eq("rst_rd_pd", rd_pd, DW'(0));
      chk_eq("rst_ram_we", DW'(ram_we), DW'(0));
      chk_eq("rst_ram_re", DW'(ram_re), DW'(0));
      chk_eq("rst_fifo_cnt", DW'(fifo_cnt), DW'(0));
      chk_eq("rst_idle", DW'(idle), DW'(1));
      chk_eq("pwrbus", DW'(ram_pwrbus_pd), DW'(pwrbus_ram_pd));
      rstn = 1'b1;
      cyc();
      chk_eq("prdy_rise", DW'(wr_prdy), DW'(1));

      // Single push latency
      wr_pvld = 1'b1;
      wr_pd   = DW'(1);
      #1;
      chk_eq("p1_we", DW'(ram_we), DW'(1));
      chk_eq("p1_wa", DW'(ram_wa), DW'(0));
      cyc();
      wr_pvld = 1'b0;
      #1;
      chk_eq("p1_re", DW'(ram_re), DW'(1));
      chk_eq("p1_ra", DW'(ram_ra), DW'(0));
      cyc();
      chk_eq("p1_pvld_early", DW'(rd_pvld), DW'(0));
      cyc();
      chk_eq("p1_pvld", DW'(rd_pvld), DW'(1));
      chk_eq("p1_pd", rd_pd, DW'(1));
      chk_eq("p1_cnt", DW'(fifo_cnt), DW'(1));
      drain();

      // Fill to full capacity
      wr_pvld = 1'b1;
      for (int i = 0; i < 700 && q.size() < DEPTH + 2; i++) begin
         wr_pd = rnd_word();
         cyc();
      end
      chk_eq("full_prdy", DW'(wr_prdy), DW'(0));
      chk_eq("full_cnt", DW'(fifo_cnt), DW'(DEPTH + 2));
      wr_pd = rnd_word();
      cyc();
      wr_pvld = 1'b0;
      rd_prdy = 1'b1;
      cyc();
      rd_prdy = 1'b0;
      waited = 0;
      while (!wr_prdy && waited < 3) begin
         cyc();
         waited++;
      end
      chk_eq("reopen_prdy", DW'(wr_prdy), DW'(1));

      // Near-full streaming: push and issue together keep wr_prdy high
      wr_pvld = 1'b1;
      rd_prdy = 1'b1;
      for (int i = 0; i < 20; i++) begin
         wr_pd = rnd_word();
         cyc();
         chk_eq("nf_prdy", DW'(wr_prdy), DW'(1));
         chk_eq("nf_cnt", DW'(fifo_cnt), DW'(DEPTH + 1));
      end
      drain();

      // Continuous streaming of 1200 incrementing words
      p0 = pops_total;
      cycles = 0;
      rd_prdy = 1'b1;
      begin
         int base;
         base = n_push;
         for (int c = 0; c < 1300 && (pops_total - p0) < 1200; c++) begin
            wr_pvld = (n_push - base) < 1200;
            wr_pd   = DW'(n_push - base);
            cyc();
            cycles++;
         end
      end
      chk_eq("stream_pops", DW'(pops_total - p0), DW'(1200));
      chk_eq("stream_rate", DW'(cycles <= 1206), DW'(1));
      drain();

      // Random producer and consumer
      for (int i = 0; i < 2500; i++) begin
         wr_pvld = ($urandom_range(0, 99) < 55);
         rd_prdy = $urandom_range(0, 1) == 1;
         wr_pd   = rnd_word();
         cyc();
      end
      drain();

      // Reset mid-stream with a read in flight
      wr_pvld = 1'b1;
      for (int i = 0; i < 100 && q.size() < 38; i++) begin
         wr_pd = rnd_word();
         cyc();
      end
      wr_pvld = 1'b0;
      repeat (4) cyc();
      rd_prdy = 1'b1;
      cyc();
      rd_prdy = 1'b0;
      chk_eq("mid_cnt", DW'(fifo_cnt), DW'(37));
      rstn = 1'b0;
      cyc();
      rstn = 1'b1;
      chk_eq("mid_rst_cnt", DW'(fifo_cnt), DW'(0));
      chk_eq("mid_rst_pvld", DW'(rd_pvld), DW'(0));
      cyc();
      for (int i = 0; i < 3; i++) begin
         chk_eq("mid_no_ghost", DW'(rd_pvld), DW'(0));
         if (i < 2) cyc();
      end
      wr_pvld = 1'b1;
      wr_pd   = DW'(8'hAB);
      #1;
      chk_eq("ab_wa", DW'(ram_wa), DW'(0));
      cyc();
      wr_pvld = 1'b0;
      #1;
      chk_eq("ab_ra", DW'(ram_ra), DW'(0));
      chk_eq("ab_re", DW'(ram_re), DW'(1));
      cyc();
      cyc();
      chk_eq("ab_pvld", DW'(rd_pvld), DW'(1));
      chk_eq("ab_pd", rd_pd, DW'(8'hAB));
      drain();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
